xor_sweep_ctrl: RTL and testbench
=================================

// Module: xor_sweep_ctrl
// PURPOSE
//  Self-test sequencer for the 4-input XOR parity datapath (e=a^b, f=c^d, g=e^f).
//  On start, it drives all 16 input vectors onto the datapath and waits a settle time
//  per vector. It then samples e/f/g and compares them with the expected parity.
//  It reports pass/fail, the error count and the first failing vector. Sits between board control and the XOR block.
// PARAMETERS
//  HOLD_CYCLES  4   cycles each vector is held before sampling; legal range >=1
//  ERR_W        5   error counter width; counter saturates at 2**ERR_W-1
// PORTS
//  clk               in   1      single system clock, rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  start             in   1      level-sampled; begins a sweep from IDLE or DONE
//  abort             in   1      cancels a running sweep
//  a_o,b_o,c_o,d_o   out  1 ea   registered stimulus to datapath a,b,c,d
//  e_i,f_i,g_i       in   1 ea   datapath outputs
//  busy              out  1      high in SETTLE/CHECK
//  done              out  1      high in DONE
//  pass              out  1      valid when done: 1 = zero mismatches
//  err_cnt           out  ERR_W  number of mismatching vectors
//  first_fail_vec    out  4      index of first mismatching vector
//  first_fail_valid  out  1      first_fail_vec holds a captured value
//  vec_idx           out  4      current vector index
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; hold counter 0. Async assert, sync release.
//  - Vector mapping: {d_o,c_o,b_o,a_o} = vec_idx (a is LSB); ascending order 0..15.
//  - Expected values: e=a^b, f=c^d, g=a^b^c^d. A vector mismatches if any of e/f/g differs.
//  - FSM: IDLE, SETTLE, CHECK, DONE.
//    IDLE   -start-> SETTLE: vec_idx=0, hold=0, err/first_fail cleared, busy=1.
//    SETTLE: hold++ each cycle; after HOLD_CYCLES cycles -> CHECK.
//    CHECK (1 cycle): sample e/f/g and compare.
//      On mismatch: err_cnt++ (saturating).
//      On the first mismatch: capture first_fail_vec=vec_idx and set first_fail_valid=1.
//      If vec_idx==15 -> DONE.
//      Else: vec_idx++, hold=0 -> SETTLE.
//    DONE: busy=0, done=1, pass=(err_cnt==0). Holds until start or abort.
//      start in DONE restarts exactly as from IDLE and clears done.
//  - Latency: done rises 16*(HOLD_CYCLES+1) cycles after the edge that samples start.
//    With HOLD_CYCLES=4 this is 80 cycles.
//  - Stimulus changes only on the SETTLE entry edge. It is stable throughout SETTLE and CHECK.
//  - start while busy: ignored.
//  - abort in SETTLE/CHECK: next edge -> IDLE. Stimulus, vec_idx, busy, err_cnt and first_fail are cleared; done stays 0.
//  - abort in DONE: -> IDLE and clears done/pass. abort in IDLE: no effect.
//  - start and abort asserted together: abort wins.
//  - rst_n low mid-sweep: immediate return to reset values; no partial results retained.
// TESTING
//  1 Golden XOR model, HOLD_CYCLES=4, 1-cycle start pulse -> busy=1 after 1 edge.
//    Expect done=1 exactly 80 cycles after start, pass=1, err_cnt=0, first_fail_valid=0.
//  2 g stuck-at-0 -> err_cnt=8, pass=0, first_fail_vec=1, first_fail_valid=1.
//  3 f inverted -> err_cnt=16, pass=0, first_fail_vec=0.
//  4 abort at cycle 30 of a sweep -> next edge busy=0, a..d_o=0, err_cnt=0, done=0.
//    Restart with start -> pass=1 after 80 cycles.
//  5 Re-pulse start at cycle 20 of a run -> ignored; done still at cycle 80.
//    Async rst_n low at cycle 40 -> all outputs 0 without waiting for a clk edge.
//  6 Finish a run with test 2's fault, then remove the fault and assert start in DONE.
//    Expect done=0 and err_cnt=0 next cycle, then pass=1 after 80 cycles.

Source files
------------

// File: rtl/xor_sweep_ctrl.sv
// xor_sweep_ctrl: self-test sequencer that sweeps all 16 vectors through the 4-input XOR parity datapath
//   clk, rst_n             : rising-edge clock, async active-low reset (synchronously released)
//   start, abort           : begin a sweep from IDLE/DONE; cancel a running sweep (abort wins)
//   a_o..d_o               : registered stimulus, {d,c,b,a} = vec_idx
//   e_i, f_i, g_i          : datapath outputs under test
//   busy, done, pass       : SETTLE/CHECK, DONE, DONE with zero mismatches
//   err_cnt                : saturating count of mismatching vectors
//   first_fail_vec/_valid  : index of the first mismatching vector and its capture flag
//   vec_idx                : vector currently driven
module xor_sweep_ctrl #(
  parameter int HOLD_CYCLES = 4,
  parameter int ERR_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             a_o,
  output logic             b_o,
  output logic             c_o,
  output logic             d_o,
  input  logic             e_i,
  input  logic             f_i,
  input  logic             g_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [3:0]       first_fail_vec,
  output logic             first_fail_valid,
  output logic [3:0]       vec_idx
);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;
  state_t state, state_n;
  logic [1:0] rst_sync;
  logic rst_q_n;
  logic [HW-1:0] hold, hold_n;
  logic [3:0] vec_n, ffv_n;
  logic [ERR_W-1:0] err_n;
  logic ffvld_n, mismatch, launch, clear;
  // reset asserts asynchronously but releases on a clock edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= '0;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_q_n = rst_sync[1];
  always_ff @(posedge clk or negedge rst_q_n)
    if (!rst_q_n) begin
      state <= IDLE;
      hold <= '0;
      vec_idx <= '0;
      err_cnt <= '0;
      first_fail_vec <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state <= state_n;
      hold <= hold_n;
      vec_idx <= vec_n;
      err_cnt <= err_n;
      first_fail_vec <= ffv_n;
      first_fail_valid <= ffvld_n;
    end
  // stimulus bits are the vector register itself, so they only move when vec_idx does
  assign {d_o, c_o, b_o, a_o} = vec_idx;
  assign busy = state == SETTLE || state == CHECK;
  assign done = state == DONE;
  assign pass = done && err_cnt == '0;
  assign mismatch = (e_i != (a_o ^ b_o)) || (f_i != (c_o ^ d_o)) || (g_i != ^vec_idx);
  assign launch = start && !abort && (state == IDLE || state == DONE);
  assign clear = abort && state != IDLE;
  always_comb begin
    state_n = state;
    hold_n = hold;
    vec_n = vec_idx;
    err_n = err_cnt;
    ffv_n = first_fail_vec;
    ffvld_n = first_fail_valid;
    if (launch || clear) begin
      state_n = launch ? SETTLE : IDLE;
      hold_n = '0;
      vec_n = '0;
      err_n = '0;
      ffv_n = '0;
      ffvld_n = 1'b0;
    end else if (state == SETTLE) begin
      hold_n = hold + 1'b1;
      state_n = hold == HW'(HOLD_CYCLES - 1) ? CHECK : SETTLE;
    end else if (state == CHECK) begin
      err_n = mismatch && !(&err_cnt) ? err_cnt + 1'b1 : err_cnt;
      ffv_n = mismatch && !first_fail_valid ? vec_idx : first_fail_vec;
      ffvld_n = first_fail_valid || mismatch;
      state_n = &vec_idx ? DONE : SETTLE;
      vec_n = &vec_idx ? vec_idx : vec_idx + 1'b1;
      hold_n = '0;
    end
  end
endmodule

// File: tb/tb_xor_sweep_ctrl.sv
// tb_xor_sweep_ctrl: randomized self-checking bench for xor_sweep_ctrl with a fault-injecting datapath model
module tb_xor_sweep_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic a_o, b_o, c_o, d_o, e_i, f_i, g_i, busy, done, pass, first_fail_valid;
  logic [4:0] err_cnt;
  logic [3:0] first_fail_vec, vec_idx, stim;
  int n_cmp = 0, n_bad = 0, mode = 0;
  logic [2:0] tbl [16];

  xor_sweep_ctrl #(.HOLD_CYCLES(4), .ERR_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .a_o(a_o), .b_o(b_o), .c_o(c_o), .d_o(d_o),
    .e_i(e_i), .f_i(f_i), .g_i(g_i),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
    .first_fail_vec(first_fail_vec), .first_fail_valid(first_fail_valid), .vec_idx(vec_idx)
  );

  always #5 clk = ~clk;
  assign stim = {d_o, c_o, b_o, a_o};

  function automatic logic [2:0] golden(input logic [3:0] v);
    return {v[0] ^ v[1], v[2] ^ v[3], ^v};
  endfunction

  // bits flipped by the injected fault, ordered {e,f,g}
  function automatic logic [2:0] fmask(input logic [3:0] v);
    return mode == 1 ? {2'b00, ^v} : mode == 2 ? 3'b010 : mode == 3 ? tbl[v] : 3'b000;
  endfunction

  always_comb {e_i, f_i, g_i} = golden(stim) ^ fmask(stim);

  function automatic void expect_result(output int errs, output int first);
    errs = 0;
    first = -1;
    for (int v = 0; v < 16; v++)
      if (fmask(4'(v)) != 3'b000) begin
        errs++;
        if (first < 0) first = v;
      end
    if (errs > 31) errs = 31;
  endfunction

  // one-cycle start pulse, then follow the sweep; lat counts edges after the start-sampling edge
  task automatic run(input int stop_at, input int repulse_at, output int lat, output int stim_bad,
                     output logic busy1, output logic done1, output logic [4:0] err1);
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    @(negedge clk) start = 1'b0;
    busy1 = busy;
    done1 = done;
    err1 = err_cnt;
    lat = 0;
    stim_bad = stim != 4'd0 ? 1 : 0;
    while (!done && lat < 200 && lat != stop_at) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      start = lat == repulse_at;
      if (!done && stim != 4'(lat / 5)) stim_bad++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_cmp++; if ({busy, done, pass, stim, err_cnt, first_fail_vec, first_fail_valid, vec_idx} !== 21'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", {busy, done, pass, stim, err_cnt, first_fail_vec, first_fail_valid, vec_idx}); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, pass, stim, err_cnt} !== 12'd0) begin n_bad++; $display("FAIL reset_release_idle: got %h want 0", {busy, done, pass, stim, err_cnt}); end
  endtask

  task automatic test_golden;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 0;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL golden_busy_after_start: got %b want 1", b1); end
    n_cmp++; if (lat != 80) begin n_bad++; $display("FAIL golden_latency: got %0d want 80", lat); end
    n_cmp++; if (sb != 0) begin n_bad++; $display("FAIL golden_stimulus_order: got %0d bad cycles want 0", sb); end
    n_cmp++; if ({done, pass, err_cnt, first_fail_valid} !== {1'b1, 1'b1, 5'd0, 1'b0}) begin n_bad++; $display("FAIL golden_result: got done=%b pass=%b err=%0d ffv=%b want 1 1 0 0", done, pass, err_cnt, first_fail_valid); end
  endtask

  task automatic test_g_stuck;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 1;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if (lat != 80) begin n_bad++; $display("FAIL gstuck_latency: got %0d want 80", lat); end
    n_cmp++; if ({pass, err_cnt} !== {1'b0, 5'd8}) begin n_bad++; $display("FAIL gstuck_errs: got pass=%b err=%0d want 0 8", pass, err_cnt); end
    n_cmp++; if ({first_fail_valid, first_fail_vec} !== {1'b1, 4'd1}) begin n_bad++; $display("FAIL gstuck_first: got valid=%b vec=%0d want 1 1", first_fail_valid, first_fail_vec); end
  endtask

  task automatic test_f_inverted;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 2;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if ({done, pass, err_cnt} !== {1'b1, 1'b0, 5'd16}) begin n_bad++; $display("FAIL finv_errs: got done=%b pass=%b err=%0d want 1 0 16", done, pass, err_cnt); end
    n_cmp++; if ({first_fail_valid, first_fail_vec} !== {1'b1, 4'd0}) begin n_bad++; $display("FAIL finv_first: got valid=%b vec=%0d want 1 0", first_fail_valid, first_fail_vec); end
  endtask

  task automatic test_abort;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 1;
    run(30, -1, lat, sb, b1, d1, e1);
    abort = 1'b1;
    @(posedge clk);
    @(negedge clk) abort = 1'b0;
    n_cmp++; if ({busy, done, stim, err_cnt, vec_idx, first_fail_valid} !== 16'd0) begin n_bad++; $display("FAIL abort_clear: got busy=%b done=%b stim=%0d err=%0d vec=%0d ffv=%b want all 0", busy, done, stim, err_cnt, vec_idx, first_fail_valid); end
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done} !== 2'b00) begin n_bad++; $display("FAIL abort_stays_idle: got busy=%b done=%b want 0 0", busy, done); end
    mode = 0;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if (lat != 80 || pass !== 1'b1) begin n_bad++; $display("FAIL abort_restart: got lat=%0d pass=%b want 80 1", lat, pass); end
  endtask

  task automatic test_start_ignored;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 0;
    run(-1, 20, lat, sb, b1, d1, e1);
    n_cmp++; if (lat != 80) begin n_bad++; $display("FAIL repulse_latency: got %0d want 80", lat); end
    n_cmp++; if (sb != 0 || pass !== 1'b1) begin n_bad++; $display("FAIL repulse_result: got stim_bad=%0d pass=%b want 0 1", sb, pass); end
  endtask

  task automatic test_async_reset;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 1;
    run(40, -1, lat, sb, b1, d1, e1);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if ({busy, done, pass, stim, err_cnt, first_fail_vec, first_fail_valid, vec_idx} !== 21'd0) begin n_bad++; $display("FAIL async_reset: got %h want 0", {busy, done, pass, stim, err_cnt, first_fail_vec, first_fail_valid, vec_idx}); end
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if ({busy, done, err_cnt} !== 7'd0) begin n_bad++; $display("FAIL async_reset_release: got busy=%b done=%b err=%0d want 0", busy, done, err_cnt); end
  endtask

  task automatic test_back_to_back;
    int lat, sb;
    logic b1, d1;
    logic [4:0] e1;
    mode = 1;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if ({done, err_cnt} !== {1'b1, 5'd8}) begin n_bad++; $display("FAIL b2b_faulty_run: got done=%b err=%0d want 1 8", done, err_cnt); end
    mode = 0;
    run(-1, -1, lat, sb, b1, d1, e1);
    n_cmp++; if ({d1, e1, b1} !== {1'b0, 5'd0, 1'b1}) begin n_bad++; $display("FAIL b2b_restart_clear: got done=%b err=%0d busy=%b want 0 0 1", d1, e1, b1); end
    n_cmp++; if (lat != 80 || pass !== 1'b1) begin n_bad++; $display("FAIL b2b_rerun: got lat=%0d pass=%b want 80 1", lat, pass); end
  endtask

  task automatic test_random;
    int lat, sb, errs, first;
    logic b1, d1;
    logic [4:0] e1;
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      for (int v = 0; v < 16; v++) tbl[v] = $urandom_range(0, 2) == 0 ? 3'($urandom) : 3'b000;
      expect_result(errs, first);
      run(-1, -1, lat, sb, b1, d1, e1);
      n_cmp++; if (lat != 80 || sb != 0) begin n_bad++; $display("FAIL rand%0d_timing: got lat=%0d stim_bad=%0d want 80 0", r, lat, sb); end
      n_cmp++; if (err_cnt !== 5'(errs) || pass !== (errs == 0)) begin n_bad++; $display("FAIL rand%0d_errs: got err=%0d pass=%b want %0d %b", r, err_cnt, pass, errs, errs == 0); end
      n_cmp++; if (first_fail_valid !== (first >= 0) || (first >= 0 && first_fail_vec !== 4'(first))) begin n_bad++; $display("FAIL rand%0d_first: got valid=%b vec=%0d want valid=%b vec=%0d", r, first_fail_valid, first_fail_vec, first >= 0, first); end
    end
  endtask

  initial begin
    test_reset;
    test_golden;
    test_g_stuck;
    test_f_inverted;
    test_abort;
    test_start_ignored;
    test_async_reset;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
